// File: rtl/mips_timer_pkg.sv
// Shared constants for the memory-mapped countdown timer.
package mips_timer_pkg;

    localparam logic [1:0] TMR_CTRL   = 2'd0;
    localparam logic [1:0] TMR_PRESET = 2'd1;
    localparam logic [1:0] TMR_COUNT  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } tmr_state_t;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;

endpackage

// File: rtl/byte_merge.sv
// Per-byte merge of a store into an existing 32-bit register value.
module byte_merge (
    input  logic [31:0] cur,
    input  logic [31:0] upd,
    input  logic [3:0]  byteen,
    output logic [31:0] merged
);

    always_comb begin
        merged = cur;
        for (int i = 0; i < 4; i++) begin
            if (byteen[i]) merged[8*i +: 8] = upd[8*i +: 8];
        end
    end

endmodule

// File: rtl/mips_timer.sv
// Countdown timer with CTRL/PRESET/COUNT registers on the M-stage data bus.
import mips_timer_pkg::*;

module mips_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [3:0]  byteen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    tmr_state_t  state;
    logic [3:0]  ctrl;
    logic [31:0] preset;
    logic [31:0] count;
    logic        pending;

    logic        sel;
    logic [1:0]  offset;
    logic        wr;
    logic        ctrl_wr;
    logic        preset_wr;
    logic        auto_reload;
    logic [31:0] ctrl_merged;
    logic [31:0] preset_merged;
    logic        ctrl_hi_unused;

    assign sel         = (addr[31:4] == BASE_ADDR[31:4]);
    assign offset      = addr[3:2];
    assign wr          = sel & we & (|byteen);
    assign ctrl_wr     = wr & (offset == TMR_CTRL);
    assign preset_wr   = wr & (offset == TMR_PRESET);
    assign auto_reload = (ctrl[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD);
    assign irq         = ctrl[CTRL_IM] & pending;

    byte_merge u_ctrl_merge (
        .cur    ({28'd0, ctrl}),
        .upd    (wdata),
        .byteen (byteen),
        .merged (ctrl_merged)
    );

    byte_merge u_preset_merge (
        .cur    (preset),
        .upd    (wdata),
        .byteen (byteen),
        .merged (preset_merged)
    );

    // Only CTRL[3:0] exist as flops; upper merged bits are dropped.
    assign ctrl_hi_unused = ^ctrl_merged[31:4];

    always_comb begin
        rdata = '0;
        if (sel) begin
            unique case (offset)
                TMR_CTRL:   rdata = {28'd0, ctrl};
                TMR_PRESET: rdata = preset;
                TMR_COUNT:  rdata = count;
                default:    rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            ctrl    <= '0;
            preset  <= '0;
            count   <= '0;
            pending <= 1'b0;
        end else begin
            if (preset_wr) preset <= preset_merged;
            if (ctrl_wr) begin
                ctrl    <= ctrl_merged[3:0];
                pending <= 1'b0;
            end
            // Later assignments override: terminal-count set beats the CPU clear.
            unique case (state)
                ST_IDLE: begin
                    if (ctrl[CTRL_EN]) state <= ST_LOAD;
                end
                ST_LOAD: begin
                    count <= preset;
                    state <= ST_CNT;
                end
                ST_CNT: begin
                    if (!ctrl[CTRL_EN]) begin
                        state <= ST_IDLE;
                    end else if (count > 32'd1) begin
                        count <= count - 32'd1;
                    end else begin
                        count   <= '0;
                        pending <= 1'b1;
                        state   <= ST_INT;
                    end
                end
                ST_INT: begin
                    if (auto_reload) begin
                        pending <= 1'b0;
                        state   <= ST_LOAD;
                    end else begin
                        if (!ctrl_wr) ctrl[CTRL_EN] <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_timer.sv
// Directed self-checking bench for the countdown timer.
module tb_mips_timer;

    localparam logic [31:0] A_CTRL = 32'h0000_7F00;
    localparam logic [31:0] A_PRE  = 32'h0000_7F04;
    localparam logic [31:0] A_CNT  = 32'h0000_7F08;
    localparam logic [31:0] A_RSV  = 32'h0000_7F0C;
    localparam logic [31:0] A_OUT  = 32'h0000_7F14;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] addr = '0;
    logic        we = 1'b0;
    logic [3:0]  byteen = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        irq;

    int n_chk = 0;
    int n_fail = 0;

    mips_timer dut (
        .clk    (clk),
        .reset  (reset),
        .addr   (addr),
        .we     (we),
        .byteen (byteen),
        .wdata  (wdata),
        .rdata  (rdata),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be);
        addr   = a;
        wdata  = d;
        byteen = be;
        we     = 1'b1;
        tick();
        we     = 1'b0;
        byteen = '0;
    endtask

    task automatic rchk(input string tag, input logic [31:0] a,
                        input logic [31:0] exp);
        addr = a;
        #1;
        chk(tag, rdata, exp);
    endtask

    task automatic ichk(input string tag, input logic exp);
        #1;
        chk(tag, {31'd0, irq}, {31'd0, exp});
    endtask

    logic [31:0] ar_cnt [5] = '{32'd3, 32'd2, 32'd1, 32'd0, 32'd0};
    logic        ar_irq [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    int          pulses;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        reset = 1'b1;
        tick();

        // reset asserted in the middle of a count
        wr(A_PRE, 32'd20, 4'hF);
        wr(A_CTRL, 32'd1, 4'hF);
        tick();
        tick();
        tick();
        tick();
        rchk("pre_reset_cnt", A_CNT, 32'd18);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rchk("rst_ctrl", A_CTRL, 32'd0);
            rchk("rst_pre", A_PRE, 32'd0);
            rchk("rst_cnt", A_CNT, 32'd0);
            ichk("rst_irq", 1'b0);
            tick();
        end
        reset = 1'b1;
        tick();
        tick();
        rchk("post_rst_cnt", A_CNT, 32'd0);
        rchk("post_rst_ctrl", A_CTRL, 32'd0);
        ichk("post_rst_irq", 1'b0);

        // one-shot, PRESET=5, EN+IM
        wr(A_PRE, 32'd5, 4'hF);
        wr(A_CTRL, 32'h9, 4'hF);
        tick();
        tick();
        for (int k = 5; k >= 1; k--) begin
            rchk("os_cnt", A_CNT, k);
            ichk("os_irq_lo", 1'b0);
            tick();
        end
        rchk("os_cnt_end", A_CNT, 32'd0);
        ichk("os_irq_hi", 1'b1);
        tick();
        ichk("os_irq_hold", 1'b1);
        rchk("os_ctrl", A_CTRL, 32'h8);
        tick();
        ichk("os_irq_hold2", 1'b1);
        wr(A_CTRL, 32'd0, 4'hF);
        ichk("os_irq_clr", 1'b0);

        // PRESET=0 behaves as 1
        wr(A_PRE, 32'd0, 4'hF);
        wr(A_CTRL, 32'h9, 4'hF);
        tick();
        tick();
        ichk("p0_irq_lo", 1'b0);
        tick();
        ichk("p0_irq_hi", 1'b1);
        wr(A_CTRL, 32'd0, 4'hF);
        ichk("p0_irq_clr", 1'b0);

        // auto-reload, PRESET=3
        wr(A_PRE, 32'd3, 4'hF);
        wr(A_CTRL, 32'hB, 4'hF);
        tick();
        tick();
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            rchk("ar_cnt", A_CNT, ar_cnt[i % 5]);
            ichk("ar_irq", ar_irq[i % 5]);
            if (irq) pulses++;
            tick();
        end
        chk("ar_pulses", pulses, 32'd4);
        wr(A_CTRL, 32'd0, 4'hF);
        tick();

        // byte-lane writes and ignored stores
        wr(A_PRE, 32'h1122_3344, 4'hF);
        wr(A_PRE, 32'h00AA_0000, 4'b0100);
        rchk("bw_pre", A_PRE, 32'h11AA_3344);
        rchk("bw_cnt_before", A_CNT, 32'd2);
        wr(A_CNT, 32'hDEAD_BEEF, 4'hF);
        rchk("bw_cnt_after", A_CNT, 32'd2);
        wr(A_PRE, 32'hFFFF_FFFF, 4'b0000);
        rchk("bw_be0", A_PRE, 32'h11AA_3344);
        wr(A_OUT, 32'hFFFF_FFFF, 4'hF);
        rchk("bw_unsel", A_PRE, 32'h11AA_3344);
        rchk("rd_rsv", A_RSV, 32'd0);
        rchk("rd_unsel", A_OUT, 32'd0);

        // disable mid-count, then re-enable
        wr(A_PRE, 32'd10, 4'hF);
        wr(A_CTRL, 32'd1, 4'hF);
        tick();
        tick();
        rchk("dis_cnt10", A_CNT, 32'd10);
        for (int i = 0; i < 4; i++) tick();
        rchk("dis_cnt6", A_CNT, 32'd6);
        wr(A_CTRL, 32'd0, 4'hF);
        rchk("dis_cnt5", A_CNT, 32'd5);
        tick();
        tick();
        tick();
        rchk("dis_frozen", A_CNT, 32'd5);
        ichk("dis_irq", 1'b0);
        wr(A_CTRL, 32'd1, 4'hF);
        tick();
        tick();
        rchk("dis_reload", A_CNT, 32'd10);
        wr(A_CTRL, 32'd0, 4'hF);
        tick();

        // CPU writes colliding with terminal count and INT
        wr(A_PRE, 32'd2, 4'hF);
        wr(A_CTRL, 32'd1, 4'hF);
        tick();
        tick();
        tick();
        rchk("sim_cnt1", A_CNT, 32'd1);
        wr(A_CTRL, 32'h9, 4'hF);
        ichk("sim_irq", 1'b1);
        rchk("sim_cnt0", A_CNT, 32'd0);
        wr(A_CTRL, 32'h9, 4'hF);
        rchk("sim_en_kept", A_CTRL, 32'h9);
        ichk("sim_irq_clr", 1'b0);
        tick();
        tick();
        rchk("sim_restart", A_CNT, 32'd2);
        wr(A_CTRL, 32'd0, 4'hF);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_timer.md
Name: mips_timer

Overview:
- Memory-mapped countdown timer on the CPU data bus; consumes the M-stage store/load port of the pipelined MIPS core (data address, write data, byte enables) and returns combinational read data in the same cycle.
- Sits between the core and the data memory behind an address decoder; raises an interrupt request line towards a future CP0/exception unit.
- Three word registers: CTRL, PRESET, COUNT.

Parameters:
- BASE_ADDR, 32'h0000_7F00, word-aligned base of the 16-byte register window (bits [3:0] must be 0).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- addr  input  32  byte address from the M stage.
- we  input  1  store strobe, qualified by byteen != 0.
- byteen  input  4  byte write enables; bit i writes wdata[8i+7:8i].
- wdata  input  32  store data, already lane-aligned by the byte-enable unit.
- rdata  output  32  read data, combinational from addr.
- irq  output  1  interrupt request = CTRL.IM & pending.

Behaviour:
- Decode: sel = (addr[31:4] == BASE_ADDR[31:4]); offset = addr[3:2]; 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved.
- Write effective when sel & we & (byteen != 0); merge per byte into the target register. Writes to COUNT and offset 3 are ignored.
- rdata: CTRL zero-extended from [3:0], PRESET, COUNT, 0 for offset 3; 0 when !sel.
- CTRL bits: [0] EN, [2:1] MODE (00 one-shot, 01 auto-reload, 1x treated as 00), [3] IM. Bits [31:4] are not stored.
- Reset (reset=0, asynchronous): CTRL=0, PRESET=0, COUNT=0, pending=0, state=IDLE. Reset is valid mid-count. rdata=0 and irq=0 while reset is low.
- FSM states IDLE, LOAD, CNT, INT; transitions evaluate the CTRL value in the register (post-write values are used from the next cycle).
  - IDLE: EN=1 -> LOAD.
  - LOAD: COUNT<=PRESET -> CNT.
  - CNT: EN=0 -> IDLE, COUNT holds. COUNT>1 -> COUNT-1, stay. COUNT<=1 -> COUNT<=0, pending<=1 -> INT.
  - INT, MODE 00: CTRL.EN<=0 -> IDLE; pending stays set.
  - INT, MODE 01: pending<=0 -> LOAD. irq is a 1-cycle pulse and the period is PRESET+2 cycles.
- Latency:
  - The EN-setting write is in cycle t. LOAD is in t+1. COUNT=PRESET is visible at t+2.
  - With PRESET=N>=1, pending rises N cycles after LOAD. PRESET=0 behaves as 1.
- pending clears on any effective CTRL write.
  - Same-cycle set (CNT->INT) beats the clear.
  - Same-cycle mode-00 auto-clear of EN loses to a CPU CTRL write (the CPU value is taken whole).
- A PRESET write during CNT does not disturb COUNT; it applies at the next LOAD.
- COUNT arithmetic is unsigned 32-bit. It never wraps below 0.

Decomposition:
- Shared constants header:
  - Register offsets (TMR_CTRL=2'd0, TMR_PRESET=2'd1, TMR_COUNT=2'd2).
  - FSM state encodings (2-bit).
  - MODE encodings and CTRL bit positions.
- One sub-module, byte_merge: a 32-bit old/new/byteen merge, reused for CTRL and PRESET writes.
- The FSM and counter stay in mips_timer.

Test Plan:
- Reset check: hold reset=0 for 3 cycles mid-count, then release. Required: rdata=0 for CTRL, PRESET and COUNT; irq=0; COUNT=0 after release.
- One-shot: write PRESET=5, then CTRL=4'b1001. Required:
  - COUNT reads 5,4,3,2,1,0.
  - irq rises 5 cycles after LOAD and stays high.
  - CTRL reads 4'b1000.
  - A CTRL write of 0 drops irq next cycle.
- Auto-reload: PRESET=3, CTRL=4'b1011. Required: irq pulses exactly 1 cycle every 5 cycles over 4 periods; COUNT sequence 3,2,1,0,0(INT),3…
- Byte writes: PRESET=32'h11223344, then store byteen=4'b0100, wdata=32'h00AA0000. Required: PRESET reads 32'h11AA3344. A store to COUNT (offset 8) leaves COUNT unchanged.
- Disable mid-count: PRESET=10, enable, clear EN at COUNT=6. Required:
  - COUNT freezes at 5 (the decrement in the write cycle still applies).
  - irq stays 0.
  - Re-enabling reloads 10.
- Simultaneous events: issue a CTRL write (IM=1, EN=1, MODE=00) in the exact CNT->INT cycle. Required: pending=1, irq=1; EN remains 1; next transition IDLE->LOAD restarts the count.
